kmap_sweep_ctrl: RTL and testbench
==================================

Name: kmap_sweep_ctrl

Overview:
Sequencer that exhaustively exercises a 4-input combinational function unit (Karnaugh-map style logic, output `out`).
It drives all 16 `{a,b,c,d}` input codes, waits a programmable settle time, then samples the function output.
Each sample is compared against an expected truth table and a care mask; don't-care positions are ignored.
Sits between a test/config host and the function unit, and reports a per-code error map, an error count and a pass flag.

Parameters:
SETTLE_CYCLES, 1, cycles each code is held before the sample cycle (legal range 0..15).
GRAY_ORDER, 0, 0 = binary code order 0..15; 1 = K-map Gray order 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8.

Ports:
clk  in  1  single clock, rising edge.
areset  in  1  asynchronous, active-high reset.
start  in  1  begin a sweep; accepted only in IDLE or DONE.
abort  in  1  stop a sweep in progress; wins over start.
exp_tbl  in  16  expected output; bit i = f at {a,b,c,d}==i.
care_mask  in  16  bit i=1 means position i is checked; 0 means don't-care.
fn_out  in  1  output of the function unit under control.
a, b, c, d  out  1 each  function-unit inputs; {a,b,c,d} is the current code.
busy  out  1  high in DRIVE/SAMPLE.
done  out  1  one-cycle pulse when a sweep completes.
pass  out  1  valid from done onward: err_cnt==0.
err_map  out  16  bit i set if a cared position i mismatched.
err_cnt  out  5  number of mismatches, 0..16.
obs_tbl  out  16  raw sampled fn_out per code.

Behaviour:
- Reset (async, immediate): state=IDLE; a..d=0; busy=0; done=0; pass=0; err_map=0; err_cnt=0; obs_tbl=0; step=0; settle counter=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE + start (and no abort):
  - latch exp_tbl and care_mask into shadow registers;
  - clear err_map, err_cnt, obs_tbl and pass;
  - step=0; go to DRIVE, or to SAMPLE if SETTLE_CYCLES==0.
- Code for a step: step when GRAY_ORDER=0; step^(step>>1) when GRAY_ORDER=1. {a,b,c,d} are registered and equal code(step) throughout DRIVE and SAMPLE.
- DRIVE: held for exactly SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE (1 cycle):
  - obs_tbl[code] <= fn_out;
  - if care_sh[code] and fn_out != exp_sh[code]: set err_map[code] and increment err_cnt.
  - If step==15, go to DONE. Otherwise step++ and go to DRIVE (or SAMPLE if SETTLE_CYCLES==0).
- Sweep latency: start seen at edge N → first code driven from N+1; done asserted in cycle N+1+16*(SETTLE_CYCLES+1).
- DONE (1 cycle): done=1, pass=(err_cnt==0); results hold until the next accepted start. With no start, the next state is IDLE.
- The shadow table/mask isolates the sweep: exp_tbl/care_mask changes while busy have no effect.
- start while busy: ignored.
- start in the DONE cycle: accepted (back-to-back sweeps).
- abort in DRIVE/SAMPLE: next state IDLE; a..d=0; no done; pass=0; err_map/err_cnt/obs_tbl keep partial values.
- abort and start in the same cycle: abort wins, state stays or goes to IDLE.
- A sample and an abort in the same cycle: the sample is still recorded.
- err_cnt cannot wrap: at most 16 samples occur per sweep.
- X on fn_out at a cared position counts as a mismatch in simulation. At a don't-care position it is only recorded in obs_tbl.

Decomposition:
- Package kmap_pkg: state enum (IDLE, DRIVE, SAMPLE, DONE); TBL_W=16; CODE_W=4; function gray_code(step) returning the 4-bit code.
- Sub-module kmap_code_gen: step counter plus binary/Gray code mapping, with GRAY_ORDER as its parameter.
- The FSM, compare logic and result registers stay in kmap_sweep_ctrl.

Test Plan:
- Matching model: bench model drives fn_out = exp_tbl[{a,b,c,d}], with exp_tbl=16'hDD0C, care_mask=16'hFFFF, SETTLE_CYCLES=1. Start at edge 0 → done in cycle 33, pass=1, err_cnt=0, err_map=16'h0000, obs_tbl=16'hDD0C.
- Single fault: same setup, model inverts its output at code 5. Required: err_map=16'h0020, err_cnt=1, pass=0, obs_tbl=16'hDD2C.
- Don't-care: care_mask=16'hDDEF (bits 4, 9, 13 clear), model inverts its output at codes 4 and 9. Required: pass=1, err_cnt=0, obs_tbl=16'hDF1C.
- Gray order: GRAY_ORDER=1, SETTLE_CYCLES=0. {a,b,c,d} on successive sample cycles = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8. done arrives 17 cycles after start; obs_tbl is still indexed by code.
- Abort: abort asserted in the 5th sample cycle, together with start. Required: IDLE next cycle, a..d=0, no done pulse, obs_tbl holds 5 recorded bits, busy=0. A later start runs a full, clean sweep.
- Reset mid-sweep: areset pulsed asynchronously between edges during DRIVE. Required: all outputs 0 immediately. start while busy is ignored, checked by a second start pulse in cycle 10 leaving done timing unchanged.

Source files
------------

// File: rtl/kmap_pkg.sv
// Shared types and helpers for the K-map sweep controller.
package kmap_pkg;
    localparam int TBL_W  = 16;
    localparam int CODE_W = 4;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    function automatic logic [CODE_W-1:0] gray_code(input logic [CODE_W-1:0] step);
        return step ^ (step >> 1);
    endfunction
endpackage

// File: rtl/kmap_sweep_ctrl_if.sv
// Host/function-unit side of the sweep controller; slave is the controller.
interface kmap_sweep_ctrl_if;
    import kmap_pkg::*;

    logic             start;
    logic             abort;
    logic [TBL_W-1:0] exp_tbl;
    logic [TBL_W-1:0] care_mask;
    logic             fn_out;
    logic             a, b, c, d;
    logic             busy;
    logic             done;
    logic             pass;
    logic [TBL_W-1:0] err_map;
    logic [4:0]       err_cnt;
    logic [TBL_W-1:0] obs_tbl;

    modport master (
        output start, abort, exp_tbl, care_mask, fn_out,
        input  a, b, c, d, busy, done, pass, err_map, err_cnt, obs_tbl
    );

    modport slave (
        input  start, abort, exp_tbl, care_mask, fn_out,
        output a, b, c, d, busy, done, pass, err_map, err_cnt, obs_tbl
    );
endinterface

// File: rtl/kmap_sweep_ctrl_code_gen.sv
// Step counter with registered binary or Gray code output.
module kmap_code_gen
    import kmap_pkg::*;
#(
    parameter bit GRAY_ORDER = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              park,
    input  logic              adv,
    output logic [CODE_W-1:0] step,
    output logic [CODE_W-1:0] code
);
    logic [CODE_W-1:0] step_nxt;

    function automatic logic [CODE_W-1:0] map_code(input logic [CODE_W-1:0] s);
        return GRAY_ORDER ? gray_code(s) : s;
    endfunction

    assign step_nxt = step + 1'b1;

    // Code is registered alongside the step so a..d never ripple through the Gray XORs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= '0;
            code <= '0;
        end else if (load) begin
            step <= '0;
            code <= map_code('0);
        end else if (park) begin
            step <= '0;
            code <= '0;
        end else if (adv) begin
            step <= step_nxt;
            code <= map_code(step_nxt);
        end
    end
endmodule

// File: rtl/kmap_sweep_ctrl.sv
// Sweeps all 16 input codes of a 4-input function unit and checks each sample
// against a shadowed expected table and care mask.
module kmap_sweep_ctrl
    import kmap_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter bit GRAY_ORDER    = 0
) (
    input  logic              clk,
    input  logic              areset,
    kmap_sweep_ctrl_if.slave  bus
);
    localparam state_t     FIRST       = (SETTLE_CYCLES == 0) ? SAMPLE : DRIVE;
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        settle_cnt;
    logic [TBL_W-1:0]  exp_sh, care_sh;
    logic [TBL_W-1:0]  err_map, obs_tbl;
    logic [4:0]        err_cnt;
    logic              pass;
    logic              load, adv, park, busy, miss;
    logic [CODE_W-1:0] step, code;

    kmap_code_gen #(.GRAY_ORDER(GRAY_ORDER)) u_code_gen (
        .clk  (clk),
        .rst  (areset),
        .load (load),
        .park (park),
        .adv  (adv),
        .step (step),
        .code (code)
    );

    assign busy = (state_q == DRIVE) || (state_q == SAMPLE);
    assign park = (state_d == IDLE) || (state_d == DONE);
    // X on fn_out must count as a mismatch, hence the case inequality.
    assign miss = care_sh[code] && (bus.fn_out !== exp_sh[code]);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start && !bus.abort) begin
                    load    = 1'b1;
                    state_d = FIRST;
                end
            end
            DRIVE: begin
                if (bus.abort)                     state_d = IDLE;
                else if (settle_cnt == SETTLE_LAST) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (bus.abort)          state_d = IDLE;
                else if (step == 4'hF)  state_d = DONE;
                else begin
                    adv     = 1'b1;
                    state_d = FIRST;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset)                                  settle_cnt <= '0;
        else if (state_q == DRIVE && state_d == DRIVE) settle_cnt <= settle_cnt + 4'd1;
        else                                         settle_cnt <= '0;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            exp_sh  <= '0;
            care_sh <= '0;
            err_map <= '0;
            err_cnt <= '0;
            obs_tbl <= '0;
            pass    <= 1'b0;
        end else begin
            if (load) begin
                exp_sh  <= bus.exp_tbl;
                care_sh <= bus.care_mask;
                err_map <= '0;
                err_cnt <= '0;
                obs_tbl <= '0;
                pass    <= 1'b0;
            end
            // The sample is taken even when an abort lands on the same cycle.
            if (state_q == SAMPLE) begin
                obs_tbl[code] <= bus.fn_out;
                if (miss) begin
                    err_map[code] <= 1'b1;
                    err_cnt       <= err_cnt + 5'd1;
                end
            end
            if (state_q == SAMPLE && state_d == DONE) pass <= (err_cnt == 5'd0) && !miss;
            if (busy && bus.abort)                    pass <= 1'b0;
        end
    end

    assign {bus.a, bus.b, bus.c, bus.d} = code;
    assign bus.busy    = busy;
    assign bus.done    = (state_q == DONE);
    assign bus.pass    = pass;
    assign bus.err_map = err_map;
    assign bus.err_cnt = err_cnt;
    assign bus.obs_tbl = obs_tbl;
endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Three controllers (binary/S=1, Gray/S=0, Gray/S=2) share one stimulus stream
// and are each checked every cycle against a timeline model of the sweep.
module tb_kmap_sweep_ctrl;
    localparam int N = 3;
    localparam logic [N-1:0][3:0] SC = {4'd2, 4'd0, 4'd1};
    localparam logic [N-1:0]      GO = 3'b110;
    localparam logic [15:0][3:0]  GSEQ = {4'h8, 4'h9, 4'hB, 4'hA, 4'hE, 4'hF, 4'hD, 4'hC,
                                          4'h4, 4'h5, 4'h7, 4'h6, 4'h2, 4'h3, 4'h1, 4'h0};

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic [15:0] exp_tbl = '0, care_mask = '0, func = '0;

    logic        dut_busy[N], dut_done[N], dut_pass[N];
    logic [15:0] dut_map[N], dut_obs[N];
    logic [4:0]  dut_cnt[N];
    logic [3:0]  dut_code[N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        kmap_sweep_ctrl_if bus();
        kmap_sweep_ctrl #(.SETTLE_CYCLES(int'(SC[g])), .GRAY_ORDER(GO[g])) dut (
            .clk(clk), .areset(areset), .bus(bus));
        assign bus.start     = start;
        assign bus.abort     = abort;
        assign bus.exp_tbl   = exp_tbl;
        assign bus.care_mask = care_mask;
        assign bus.fn_out    = func[{bus.a, bus.b, bus.c, bus.d}];
        assign dut_busy[g]   = bus.busy;
        assign dut_done[g]   = bus.done;
        assign dut_pass[g]   = bus.pass;
        assign dut_map[g]    = bus.err_map;
        assign dut_obs[g]    = bus.obs_tbl;
        assign dut_cnt[g]    = bus.err_cnt;
        assign dut_code[g]   = {bus.a, bus.b, bus.c, bus.d};
    end

    int total = 0, bad = 0, cyc = 0, s_edge = 0;
    int done_cyc[N];

    // Model: a sweep is a timeline of 16*(S+1) cycles; the last of each S+1 group samples.
    bit          m_busy[N], m_done[N], m_pass[N], m_cdk[N];
    int          m_pos[N], m_cnt[N];
    logic [15:0] m_obs[N], m_map[N], m_exp[N], m_care[N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [3:0] code_of(input int i, input int s);
        logic [3:0] st;
        st = 4'(s);
        return GO[i] ? GSEQ[st] : st;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_cdk[i] = 1;
            m_pos[i] = 0; m_cnt[i] = 0; m_obs[i] = '0; m_map[i] = '0;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < N; i++) begin
            int s;
            logic [3:0] cd;
            s = int'(SC[i]);
            if (m_busy[i]) begin
                if (m_pos[i] % (s + 1) == s) begin
                    cd = code_of(i, m_pos[i] / (s + 1));
                    m_obs[i][cd] = func[cd];
                    if (m_care[i][cd] && func[cd] != m_exp[i][cd]) begin
                        m_map[i][cd] = 1'b1;
                        m_cnt[i]++;
                    end
                end
                if (abort) begin
                    m_busy[i] = 0; m_pass[i] = 0; m_cdk[i] = 1;
                end else if (m_pos[i] == 16 * (s + 1) - 1) begin
                    m_busy[i] = 0; m_done[i] = 1; m_pass[i] = (m_cnt[i] == 0); m_cdk[i] = 0;
                end else begin
                    m_pos[i]++;
                end
            end else begin
                m_done[i] = 0;
                if (start && !abort) begin
                    m_exp[i] = exp_tbl; m_care[i] = care_mask;
                    m_obs[i] = '0; m_map[i] = '0; m_cnt[i] = 0; m_pass[i] = 0;
                    m_busy[i] = 1; m_pos[i] = 0; m_cdk[i] = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("busy%0d", i), 32'(dut_busy[i]), 32'(m_busy[i]));
            chk($sformatf("done%0d", i), 32'(dut_done[i]), 32'(m_done[i]));
            chk($sformatf("pass%0d", i), 32'(dut_pass[i]), 32'(m_pass[i]));
            chk($sformatf("err_map%0d", i), 32'(dut_map[i]), 32'(m_map[i]));
            chk($sformatf("err_cnt%0d", i), 32'(dut_cnt[i]), 32'(m_cnt[i]));
            chk($sformatf("obs_tbl%0d", i), 32'(dut_obs[i]), 32'(m_obs[i]));
            if (m_cdk[i])
                chk($sformatf("abcd%0d", i), 32'(dut_code[i]),
                    32'(m_busy[i] ? code_of(i, m_pos[i] / (int'(SC[i]) + 1)) : 4'h0));
            if (dut_done[i]) done_cyc[i] = cyc + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_update();
        #1 check_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic sweep_start();
        for (int i = 0; i < N; i++) done_cyc[i] = -1;
        start = 1'b1;
        tick();
        s_edge = cyc;
        start = 1'b0;
    endtask

    task automatic chk_result(input string nm, input logic [15:0] map, input int cnt,
                              input bit ps, input logic [15:0] obs);
        chk({nm, "_map"}, 32'(dut_map[0]), 32'(map));
        chk({nm, "_cnt"}, 32'(dut_cnt[0]), 32'(cnt));
        chk({nm, "_pass"}, 32'(dut_pass[0]), 32'(ps));
        chk({nm, "_obs"}, 32'(dut_obs[0]), 32'(obs));
    endtask

    initial begin
        model_reset();
        #2 check_all();
        @(posedge clk);
        #1 areset = 1'b0;

        // Matching function unit
        exp_tbl = 16'hDD0C; care_mask = 16'hFFFF; func = 16'hDD0C;
        sweep_start();
        run(52);
        chk("t1_done_bin", 32'(done_cyc[0]), 32'(s_edge + 33));
        chk("t1_done_gray0", 32'(done_cyc[1]), 32'(s_edge + 17));
        chk("t1_done_gray2", 32'(done_cyc[2]), 32'(s_edge + 49));
        chk_result("t1", 16'h0000, 0, 1'b1, 16'hDD0C);

        // Single fault at code 5
        func = 16'hDD2C;
        sweep_start();
        run(52);
        chk_result("t2", 16'h0020, 1, 1'b0, 16'hDD2C);
        chk("t2_map_gray", 32'(dut_map[1]), 32'h0020);

        // Faults only at don't-care positions 4 and 9
        care_mask = 16'hDDEF; func = 16'hDF1C;
        sweep_start();
        run(52);
        chk_result("t3", 16'h0000, 0, 1'b1, 16'hDF1C);
        chk("t3_obs_gray0", 32'(dut_obs[1]), 32'hDF1C);
        chk("t3_obs_gray2", 32'(dut_obs[2]), 32'hDF1C);

        // Abort with start in the 5th sample cycle of the binary unit
        care_mask = 16'hFFFF; func = 16'hDD0C;
        sweep_start();
        run(9);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("ab_busy", 32'(dut_busy[0]), 32'h0);
        chk("ab_abcd", 32'(dut_code[0]), 32'h0);
        chk("ab_obs", 32'(dut_obs[0]), 32'h000C);
        for (int i = 0; i < N; i++) done_cyc[i] = -1;
        run(60);
        chk("ab_no_done", 32'(done_cyc[0]), 32'hFFFF_FFFF);
        sweep_start();
        run(52);
        chk_result("ab_rerun", 16'h0000, 0, 1'b1, 16'hDD0C);

        // Asynchronous reset during DRIVE, then a start while busy
        func = 16'h5A3C;
        sweep_start();
        #2 areset = 1'b1;
        #1 model_reset();
        check_all();
        chk("rst_busy", 32'(dut_busy[0]), 32'h0);
        chk("rst_abcd", 32'(dut_code[0]), 32'h0);
        #1 areset = 1'b0;
        sweep_start();
        run(9);
        start = 1'b1;
        tick();
        start = 1'b0;
        run(45);
        chk("busy_start_done0", 32'(done_cyc[0]), 32'(s_edge + 33));
        chk("busy_start_done2", 32'(done_cyc[2]), 32'(s_edge + 49));

        // Randomized traffic, including table changes while busy
        for (int k = 0; k < 1500; k++) begin
            start     = ($urandom_range(7) == 0);
            abort     = ($urandom_range(49) == 0);
            exp_tbl   = 16'($urandom);
            care_mask = 16'($urandom);
            if ($urandom_range(15) == 0) func = 16'($urandom);
            tick();
        end
        start = 1'b0; abort = 1'b0;
        run(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
